drive_supervisor: RTL and testbench
===================================

# drive_supervisor

Registered successor to the combinational vehicle/CPU control logic. Tracks a trip through a four-state machine (idle, driving, parked, stranded) from a start pulse, a debounced arrival flag and a multi-bit fuel level. Drives a thermal shut-off for the on-board computer with hysteresis and an optional minimum-off hold. Sits between the vehicle sensor front end and the drivetrain/computer power controllers; all outputs are registered.

## Interface
- TEMP_W, 8: width of cpu_temp.
- HOT_THRESH, 100: cpu_temp at or above this value sets shut-off.
- COOL_THRESH, 80: cpu_temp at or below this value allows shut-off to clear. Must be less than HOT_THRESH.
- FUEL_W, 8: width of fuel_level.
- RESERVE_LVL, 16: fuel_level below this value is low fuel. Must be greater than 0.
- ARRIVE_DEBOUNCE, 3: consecutive sampled cycles arrived must be high to count as arrival. Must be at least 1.
- MIN_OFF_CYCLES, 8: minimum number of cycles shut_off_computer stays high. Must be at least 1.
- clk  in  1  single clock; all state changes on the rising edge.
- areset  in  1  reset, asynchronous and active-high.
- start  in  1  single-cycle trip request.
- arrived  in  1  destination-reached flag, raw (not debounced).
- fuel_level  in  FUEL_W  current fuel level, unsigned.
- cpu_temp  in  TEMP_W  CPU temperature, unsigned.
- keep_driving  out  1  high exactly when state is DRIVE.
- shut_off_computer  out  1  thermal shut-off request.
- low_fuel_warn  out  1  registered (fuel_level < RESERVE_LVL).
- state  out  2  encoding: IDLE=0, DRIVE=1, PARKED=2, STRANDED=3.

## Operation
- On reset: state=IDLE, keep_driving=0, shut_off_computer=0, low_fuel_warn=0. The debounce counter and hold counter clear to 0.
- IDLE: go to DRIVE when start=1 and fuel_level!=0. Otherwise stay.
- DRIVE:
  - If fuel_level==0, go to STRANDED. This has priority over arrival.
  - Otherwise, if arrived has been high for ARRIVE_DEBOUNCE consecutive edges, go to PARKED.
  - start is ignored in this state.
- PARKED: go to DRIVE when start=1 and fuel_level!=0. Otherwise stay. arrived is ignored.
- STRANDED: go to IDLE when fuel_level>=RESERVE_LVL (refuelled). start is ignored.
- Debounce counter:
  - Width is clog2(ARRIVE_DEBOUNCE+1).
  - Increments on each edge where state==DRIVE and arrived=1.
  - Clears on any edge where arrived=0 or state!=DRIVE.
  - The transition fires on the edge where the count would reach ARRIVE_DEBOUNCE. The counter saturates and never wraps.
- Thermal logic (independent of the FSM):
  - Set shut_off_computer when cpu_temp>=HOT_THRESH.
  - Clear it when cpu_temp<=COOL_THRESH and the hold condition is satisfied.
  - For COOL_THRESH<cpu_temp<HOT_THRESH, hold the previous value.
  - While shut_off_computer is already high, a sample at or above HOT_THRESH does not reload the hold counter.
- All comparisons are unsigned and at full parameter width. There is no arithmetic overflow path.

## Timing
- All outputs are registered. An input sampled at edge N is reflected in the outputs immediately after edge N; latency is one edge.
- start at edge N (IDLE, fuel>0): state=DRIVE and keep_driving=1 after edge N.
- arrived high on edges N..N+ARRIVE_DEBOUNCE-1: PARKED after edge N+ARRIVE_DEBOUNCE-1. A low sample in between restarts the count.
- fuel_level=0 together with completed debounce on the same edge: STRANDED.
- areset asserted mid-trip: outputs go to reset values immediately, with no clock required. Release is synchronous to the next edge.

## Configuration
- SHUTOFF_MIN_HOLD_EN defined:
  - On the set edge, the hold counter loads MIN_OFF_CYCLES-1.
  - The counter decrements on each following edge while shut_off_computer is high.
  - Clearing is allowed only when the counter is 0. shut_off_computer is therefore high for at least MIN_OFF_CYCLES cycles.
- SHUTOFF_MIN_HOLD_EN undefined: the hold counter is not built, MIN_OFF_CYCLES is unused, and clearing depends on hysteresis alone.

## Test plan
- Reset, then fuel=50, pulse start: after one edge, state=1 and keep_driving=1. Hold arrived=1 for 3 edges: state=2, keep_driving=0.
- DRIVE, arrived pattern 1,1,0,1,1,1: PARKED only after the sixth edge.
- DRIVE, fuel=0 and third arrived edge together: state=3. Then fuel=15: still 3, low_fuel_warn=1. Then fuel=16: state=0, low_fuel_warn=0.
- cpu_temp=100 for one cycle, then 50 (macro defined): shut_off_computer high for exactly 8 cycles. Macro undefined: high for exactly 1 cycle.
- cpu_temp sequence 100, 90, 81, 80 (hold expired): shut-off stays 1 through 81 and clears after the edge sampling 80.
- areset pulsed mid-DRIVE with shut-off high: all outputs 0 and state=0 immediately, without a clock edge.

Source files
------------

// File: rtl/drive_supervisor.sv
// drive_supervisor: registered trip FSM with debounced arrival, low-fuel warning and thermal shut-off (optional min-off hold via SHUTOFF_MIN_HOLD_EN)
module drive_supervisor #(
  parameter int TEMP_W          = 8,
  parameter int HOT_THRESH      = 100,
  parameter int COOL_THRESH     = 80,
  parameter int FUEL_W          = 8,
  parameter int RESERVE_LVL     = 16,
  parameter int ARRIVE_DEBOUNCE = 3,
  parameter int MIN_OFF_CYCLES  = 8
) (
  input  logic              clk,
  input  logic              areset,
  input  logic              start,
  input  logic              arrived,
  input  logic [FUEL_W-1:0] fuel_level,
  input  logic [TEMP_W-1:0] cpu_temp,
  output logic              keep_driving,
  output logic              shut_off_computer,
  output logic              low_fuel_warn,
  output logic [1:0]        state
);
  typedef enum logic [1:0] {IDLE = 2'd0, DRIVE = 2'd1, PARKED = 2'd2, STRANDED = 2'd3} state_t;
  localparam int DW = $clog2(ARRIVE_DEBOUNCE + 1);
  localparam logic [DW-1:0] DB_LAST = DW'(ARRIVE_DEBOUNCE - 1);
  localparam logic [DW-1:0] DB_MAX = DW'(ARRIVE_DEBOUNCE);
  localparam logic [TEMP_W-1:0] HOT = TEMP_W'(HOT_THRESH);
  localparam logic [TEMP_W-1:0] COOL = TEMP_W'(COOL_THRESH);
  localparam logic [FUEL_W-1:0] RESERVE = FUEL_W'(RESERVE_LVL);
  state_t state_q, state_d;
  logic [DW-1:0] dbc_q, dbc_d;
  logic keep_driving_q, keep_driving_d;
  logic shut_off_q, shut_off_d;
  logic low_fuel_q, low_fuel_d;
  logic fuel_empty, hot, cool, hold_done, dbc_hit;
  assign fuel_empty = fuel_level == '0;
  assign hot = cpu_temp >= HOT;
  assign cool = cpu_temp <= COOL;
  assign dbc_hit = state_q == DRIVE && arrived && dbc_q == DB_LAST;
  assign keep_driving = keep_driving_q;
  assign shut_off_computer = shut_off_q;
  assign low_fuel_warn = low_fuel_q;
  assign state = state_q;
`ifdef SHUTOFF_MIN_HOLD_EN
  localparam int HW = $clog2(MIN_OFF_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_INIT = HW'(MIN_OFF_CYCLES - 1);
  logic [HW-1:0] hold_q, hold_d;
  assign hold_done = hold_q == '0;
  // hold counter: loads only on the rising set edge, then counts down while shut-off is high
  always_comb hold_d = (hot && !shut_off_q) ? HOLD_INIT : (shut_off_q && !hold_done) ? hold_q - HW'(1) : hold_q;
  // hold counter register
  always_ff @(posedge clk or posedge areset)
    if (areset) hold_q <= '0;
    else hold_q <= hold_d;
`else
  localparam int UNUSED_MIN_OFF = MIN_OFF_CYCLES;
  assign hold_done = 1'b1;
`endif
  // next-state, saturating arrival debounce and registered output values
  always_comb begin
    unique case (state_q)
      IDLE, PARKED: state_d = (start && !fuel_empty) ? DRIVE : state_q;
      DRIVE:        state_d = fuel_empty ? STRANDED : dbc_hit ? PARKED : DRIVE;
      default:      state_d = (fuel_level >= RESERVE) ? IDLE : STRANDED;
    endcase
    dbc_d = (state_q == DRIVE && arrived) ? ((dbc_q == DB_MAX) ? dbc_q : dbc_q + DW'(1)) : '0;
    keep_driving_d = state_d == DRIVE;
    shut_off_d = hot || (shut_off_q && !(cool && hold_done));
    low_fuel_d = fuel_level < RESERVE;
  end
  // state and output registers, cleared asynchronously
  always_ff @(posedge clk or posedge areset)
    if (areset) begin
      state_q        <= IDLE;
      dbc_q          <= '0;
      keep_driving_q <= 1'b0;
      shut_off_q     <= 1'b0;
      low_fuel_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      dbc_q          <= dbc_d;
      keep_driving_q <= keep_driving_d;
      shut_off_q     <= shut_off_d;
      low_fuel_q     <= low_fuel_d;
    end
endmodule

// File: tb/tb_drive_supervisor.sv
// tb_drive_supervisor: directed scoreboard bench for drive_supervisor
module tb_drive_supervisor;
`ifdef SHUTOFF_MIN_HOLD_EN
  localparam int SO_CYC = 8;
  localparam bit HOLD = 1'b1;
`else
  localparam int SO_CYC = 1;
  localparam bit HOLD = 1'b0;
`endif
  logic clk = 1'b0;
  logic areset, start, arrived;
  logic [7:0] fuel_level, cpu_temp;
  logic keep_driving, shut_off_computer, low_fuel_warn;
  logic [1:0] state;
  int tests = 0;
  int fails = 0;
  logic [3:0] exp_q[$];
  string tag_q[$];
  drive_supervisor dut (
    .clk(clk), .areset(areset), .start(start), .arrived(arrived),
    .fuel_level(fuel_level), .cpu_temp(cpu_temp), .keep_driving(keep_driving),
    .shut_off_computer(shut_off_computer), .low_fuel_warn(low_fuel_warn), .state(state)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic check_outputs(input string tag, input logic [3:0] e);
    chk({tag, ".state"}, {6'd0, state}, {6'd0, e[3:2]});
    chk({tag, ".keep_driving"}, {7'd0, keep_driving}, {7'd0, e[3:2] == 2'd1});
    chk({tag, ".shut_off"}, {7'd0, shut_off_computer}, {7'd0, e[1]});
    chk({tag, ".low_fuel"}, {7'd0, low_fuel_warn}, {7'd0, e[0]});
  endtask
  task automatic step(input logic s, input logic a, input logic [7:0] f, input logic [7:0] t,
                      input logic [1:0] es, input logic eso, input logic elf, input string tag);
    start = s;
    arrived = a;
    fuel_level = f;
    cpu_temp = t;
    exp_q.push_back({es, eso, elf});
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
    check_outputs(tag_q.pop_front(), exp_q.pop_front());
    @(negedge clk);
  endtask
  initial begin
    areset = 1'b1;
    start = 1'b0;
    arrived = 1'b0;
    fuel_level = 8'd50;
    cpu_temp = 8'd50;
    repeat (2) @(negedge clk);
    check_outputs("reset", 4'b0000);
    areset = 1'b0;
    step(1, 0, 50, 50, 2'd1, 0, 0, "start");
    step(0, 1, 50, 50, 2'd1, 0, 0, "arr1");
    step(0, 1, 50, 50, 2'd1, 0, 0, "arr2");
    step(0, 1, 50, 50, 2'd2, 0, 0, "arr3_parked");
    step(0, 1, 50, 50, 2'd2, 0, 0, "parked_hold");
    step(1, 0, 50, 50, 2'd1, 0, 0, "restart");
    step(0, 1, 50, 50, 2'd1, 0, 0, "pat1");
    step(0, 1, 50, 50, 2'd1, 0, 0, "pat2");
    step(0, 0, 50, 50, 2'd1, 0, 0, "pat3_low");
    step(0, 1, 50, 50, 2'd1, 0, 0, "pat4");
    step(0, 1, 50, 50, 2'd1, 0, 0, "pat5");
    step(0, 1, 50, 50, 2'd2, 0, 0, "pat6_parked");
    step(1, 0, 50, 50, 2'd1, 0, 0, "restart2");
    step(0, 1, 50, 50, 2'd1, 0, 0, "sarr1");
    step(0, 1, 50, 50, 2'd1, 0, 0, "sarr2");
    step(0, 1, 0, 50, 2'd3, 0, 1, "empty_prio");
    step(1, 0, 15, 50, 2'd3, 0, 1, "fuel15");
    step(0, 0, 16, 50, 2'd0, 0, 0, "fuel16");
    step(1, 0, 0, 50, 2'd0, 0, 1, "idle_empty_start");
    step(0, 0, 50, 50, 2'd0, 0, 0, "idle_refill");
    step(0, 0, 50, 100, 2'd0, 1, 0, "hot_set");
    for (int i = 1; i <= 8; i++)
      step(0, 0, 50, 50, 2'd0, i < SO_CYC, 0, $sformatf("pulse_%0d", i));
    step(0, 0, 50, 100, 2'd0, 1, 0, "hot_set2");
    for (int i = 1; i <= 3; i++)
      step(0, 0, 50, 100, 2'd0, 1, 0, $sformatf("hot_again_%0d", i));
    for (int i = 4; i <= 8; i++)
      step(0, 0, 50, 50, 2'd0, HOLD && i < 8, 0, $sformatf("no_reload_%0d", i));
    step(0, 0, 50, 100, 2'd0, 1, 0, "hyst_set");
    for (int i = 1; i <= 8; i++)
      step(0, 0, 50, 90, 2'd0, 1, 0, $sformatf("hyst90_%0d", i));
    step(0, 0, 50, 81, 2'd0, 1, 0, "hyst81");
    step(0, 0, 50, 80, 2'd0, 0, 0, "hyst80");
    step(1, 0, 50, 100, 2'd1, 1, 0, "pre_reset");
    start = 1'b0;
    #2;
    areset = 1'b1;
    #1;
    check_outputs("async_reset", 4'b0000);
    @(negedge clk);
    areset = 1'b0;
    step(0, 0, 50, 50, 2'd0, 0, 0, "post_reset");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
